// File: rtl/rv_dpram_be.sv
// rtl/rv_dpram_be.sv - simple dual-port RAM with byte enables, 1/2-cycle read latency and post-reset zero fill
//
// Port A writes, port B reads. Both ports are gated by init_done, which stays
// low while the optional zero-fill sequencer clears the array after reset.
//
// Ports:
//   clk       - clock, all state on the rising edge
//   rst_n     - asynchronous active-low reset
//   wena      - port A write request
//   wbe       - port A byte-lane enables (lane i covers dina[i*BYTE +: BYTE])
//   addra     - port A write address
//   dina      - port A write data
//   renb      - port B read request
//   addrb     - port B read address
//   doutb     - port B read data, holds its last value between reads
//   doutb_vld - one-cycle strobe marking a completed read on doutb
//   init_done - high once the memory accepts requests

module rv_dpram_be #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 1024,
    parameter int BYTE     = 8,
    parameter int RD_LAT   = 1,
    parameter int RDW_MODE = 0,
    parameter int INIT_CLR = 1,
    localparam int NB      = WIDTH / BYTE,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wena,
    input  logic [NB-1:0]    wbe,
    input  logic [AW-1:0]    addra,
    input  logic [WIDTH-1:0] dina,
    input  logic             renb,
    input  logic [AW-1:0]    addrb,
    output logic [WIDTH-1:0] doutb,
    output logic             doutb_vld,
    output logic             init_done
);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam state_t        RST_STATE = (INIT_CLR != 0) ? CLEAR : READY;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    // One extra bit so the range check also works when DEPTH is a power of two.
    localparam logic [AW:0]   DEPTH_X   = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    state_t        state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;
    logic          fill_we;

    logic             wr_in_range, rd_in_range;
    logic             wr_acc, rd_acc;
    logic [WIDTH-1:0] rd_word;

    // Fill sequencer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RST_STATE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        fill_we   = 1'b0;
        case (state)
            CLEAR: begin
                fill_we = 1'b1;
                if (cnt == LAST_ADDR) begin
                    state_nxt = READY;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            READY: begin
                state_nxt = READY;
            end
            default: begin
                state_nxt = RST_STATE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign init_done = (state == READY);

    // Request qualification
    assign wr_in_range = ({1'b0, addra} < DEPTH_X);
    assign rd_in_range = ({1'b0, addrb} < DEPTH_X);
    assign wr_acc      = wena & init_done & wr_in_range;
    assign rd_acc      = renb & init_done;

    // Read word: out-of-range reads return zero; in new-data mode a same-address
    // write in this cycle overrides the lanes it enables.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[addrb];
            if ((RDW_MODE != 0) && wr_acc && (addra == addrb)) begin
                for (int i = 0; i < NB; i++) begin
                    if (wbe[i]) begin
                        rd_word[i*BYTE +: BYTE] = dina[i*BYTE +: BYTE];
                    end
                end
            end
        end
    end

    // Array write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            mem[cnt] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < NB; i++) begin
                if (wbe[i]) begin
                    mem[addra][i*BYTE +: BYTE] <= dina[i*BYTE +: BYTE];
                end
            end
        end
    end

    // Read pipeline; doutb only loads on a completing read so it holds otherwise.
    generate
        if (RD_LAT == 2) begin : g_lat2
            logic             p1_vld;
            logic [WIDTH-1:0] p1_data;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    p1_vld    <= 1'b0;
                    p1_data   <= '0;
                    doutb     <= '0;
                    doutb_vld <= 1'b0;
                end else begin
                    p1_vld    <= rd_acc;
                    doutb_vld <= p1_vld;
                    if (rd_acc) begin
                        p1_data <= rd_word;
                    end
                    if (p1_vld) begin
                        doutb <= p1_data;
                    end
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    doutb     <= '0;
                    doutb_vld <= 1'b0;
                end else begin
                    doutb_vld <= rd_acc;
                    if (rd_acc) begin
                        doutb <= rd_word;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: doc/rv_dpram_be.md
# rv_dpram_be

Parametrised simple dual-port block RAM with per-byte write enables, selectable read latency, defined read-during-write behaviour, a read-valid strobe and an optional post-reset zero-fill sequencer. It is the general-purpose storage primitive for instruction/data memories and register-file-like buffers in the core. It replaces plain word-write RAMs wherever sub-word stores, deterministic contents or pipelined read timing are required.

## Interface
- WIDTH, 32, data width in bits; must be a multiple of BYTE
- DEPTH, 1024, number of words; DEPTH >= 2, need not be a power of two
- BYTE, 8, bits per write-enable lane; NB = WIDTH/BYTE
- RD_LAT, 1, read latency in cycles; legal values 1 or 2
- RDW_MODE, 0, same-address read-during-write: 0 = old data, 1 = new (merged) data
- INIT_CLR, 1, 1 = zero-fill all words after reset; 0 = no fill, contents undefined
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wena  in  1  write request, port A
- wbe  in  NB  byte-lane enables; lane i covers dina[i*BYTE +: BYTE]
- addra  in  AW  write address; AW = clog2(DEPTH)
- dina  in  WIDTH  write data
- renb  in  1  read request, port B
- addrb  in  AW  read address
- doutb  out  WIDTH  read data
- doutb_vld  out  1  one-cycle strobe, doutb carries a completed read
- init_done  out  1  memory ready; requests are ignored while low

## Operation
- Reset (async assert): doutb = 0, doutb_vld = 0, fill counter = 0, pipeline valids cleared, init_done = 0 if INIT_CLR = 1, else 1. Array contents are not reset.
- Fill FSM, states CLEAR and READY:
  - Reset enters CLEAR if INIT_CLR = 1, else READY.
  - In CLEAR, each cycle writes all-zero to address cnt, then cnt increments.
  - After the write to DEPTH-1 the FSM moves to READY and init_done goes 1.
  - READY is terminal until the next reset.
  - During CLEAR, wena and renb are ignored: no write, no read, no doutb_vld.
  - Reset asserted mid-CLEAR restarts the fill from address 0.
- Write: when wena & init_done, each lane i with wbe[i] = 1 is updated from dina. Lanes with wbe[i] = 0 are unchanged. wbe = 0 is a no-op.
- Read: when renb & init_done, the word at addrb is captured and delivered RD_LAT cycles later with doutb_vld = 1.
  - Every accepted read produces exactly one strobe, in order; back-to-back reads are sustained at one per cycle.
  - When no read completes, doutb holds its last value and doutb_vld = 0.
- Read-during-write, same cycle and same address:
  - RDW_MODE = 0: the read returns the pre-write word.
  - RDW_MODE = 1: the read returns lanes with wbe set from dina and other lanes from the old word.
  - Different addresses never interact.
- Out of range (address >= DEPTH): the write is dropped; the read returns 0 and still strobes doutb_vld.
- Simultaneous reads and writes to different addresses proceed independently every cycle.

## Timing
- RD_LAT = 1: renb sampled at edge t gives doutb/doutb_vld valid after edge t+1.
- RD_LAT = 2: the same read is valid after edge t+2; the second stage is a plain register with no stall.
- Write visible to a port-B read issued the cycle after the write edge, in both RDW modes.
- Fill duration: exactly DEPTH cycles from the first clk edge after rst_n deassertion to init_done = 1. A request presented in the cycle init_done first reads 1 is accepted.
- No back-pressure: doutb_vld cannot be stalled; the consumer must accept it.

## Test plan
- Reset/fill: WIDTH=32, DEPTH=16, INIT_CLR=1. Release rst_n, then read all 16 addresses after init_done → init_done rises exactly 16 cycles after release; every word reads 0x00000000; no doutb_vld seen during CLEAR.
- Byte lanes: write 0xAABBCCDD wbe=4'hF to addr 3, then 0x11223344 wbe=4'b0101 → read addr 3 returns 0xAA22CC44.
- RDW collision: with addr 5 = 0x12345678, write 0xFFFFFFFF wbe=4'b0011 and read addr 5 in the same cycle → RDW_MODE=0 returns 0x12345678; RDW_MODE=1 returns 0x1234FFFF.
- Latency/throughput: RD_LAT=2. Issue reads to addrs 0,1,2 on consecutive cycles holding 0xA,0xB,0xC → doutb_vld high for 3 consecutive cycles starting 2 cycles after the first renb; data is 0xA,0xB,0xC in order.
- Reset mid-fill: assert rst_n low at fill address 7, then release → init_done stays 0, fill restarts at 0, init_done rises 16 cycles after the second release; a write attempted during CLEAR is absent afterwards.
- Out of range: DEPTH=12. Write 0x5 to addr 13 and read addr 13 → no array change (addrs 0–11 unchanged); the read returns 0 with doutb_vld = 1.
